ctrl_pipe_unit: RTL

- Parametrised pipelined successor to the single-cycle control decoder of the 5-stage MIPS core.
- Decodes the ID-stage opcode/funct into the existing control encoding and registers the control bundle through the ID/EX, EX/MEM and MEM/WB stages.
- Owns load-use / RAW hazard stalling with a multi-cycle stall counter, jump flush in ID and taken-branch flush from EX.

---
 rtl/ctrl_pipe_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes the ID instruction, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, and owns load-use/RAW stalls plus jump/branch flushes.
module ctrl_pipe_unit #(
  parameter int REG_AW       = 5,
  parameter int ALUOP_W      = 4,
  parameter int STALL_CYCLES = 1,
  parameter int ENABLE_FWD   = 1
) (
  input  logic               CLK,
  input  logic               CTRL_UNIT_RST,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [REG_AW-1:0]  rs,
  input  logic [REG_AW-1:0]  rt,
  input  logic [REG_AW-1:0]  rd,
  input  logic               branch_taken_ex,
  output logic               stall_if_id,
  output logic               flush_if_id,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_src_a,
  output logic               ex_src_b,
  output logic               ex_branch,
  output logic               ex_mem_read,
  output logic               ex_reg_write,
  output logic [REG_AW-1:0]  ex_dest,
  output logic               ex_illegal,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               mem_reg_write,
  output logic [REG_AW-1:0]  mem_dest,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_jal,
  output logic [REG_AW-1:0]  wb_dest
);

  localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRL = 4'd2, ALU_OR  = 4'd3, ALU_AND = 4'd4,
    ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_XOR = 4'd7, ALU_SLL = 4'd8, ALU_SRA = 4'd9
  } aluCode_t;

  aluCode_t           decAlu;
  logic               decSrcA, decSrcB, decBranch, decMemRead, decMemWrite, decMemToReg;
  logic               decRegWrite, decJal, decJump, decIllegal, usesRs, usesRt;
  logic [REG_AW-1:0]  decDest;
  logic               regWriteEff, exMatch, memMatch, loadUse, rawHazard;
  logic               stall, flush, bubble;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic               exMemWrite, exMemToReg, exJal, memJal;

  always_comb begin
    decAlu = ALU_ADD;
    decSrcA = 1'b0; decSrcB = 1'b0; decBranch = 1'b0; decMemRead = 1'b0;
    decMemWrite = 1'b0; decMemToReg = 1'b0; decRegWrite = 1'b0; decJal = 1'b0;
    decJump = 1'b0; decIllegal = 1'b0; usesRs = 1'b0; usesRt = 1'b0;
    decDest = '0;
    case (opcode)
      6'h00: begin
        usesRs = 1'b1; usesRt = 1'b1; decDest = rd; decRegWrite = 1'b1;
        case (funct)
          6'h20, 6'h21: decAlu = ALU_ADD;
          6'h22, 6'h23: decAlu = ALU_SUB;
          6'h24:        decAlu = ALU_AND;
          6'h25:        decAlu = ALU_OR;
          6'h26:        decAlu = ALU_XOR;
          6'h27:        decAlu = ALU_NOR;
          6'h2a, 6'h2b: decAlu = ALU_SLT;
          // Variable shifts (funct bit 2 set) read rs; immediate shifts do not.
          6'h00, 6'h04: begin decAlu = ALU_SLL; decSrcA = 1'b1; usesRs = funct[2]; end
          6'h02, 6'h06: begin decAlu = ALU_SRL; decSrcA = 1'b1; usesRs = funct[2]; end
          6'h03, 6'h07: begin decAlu = ALU_SRA; decSrcA = 1'b1; usesRs = funct[2]; end
          6'h08:        begin decRegWrite = 1'b0; decJump = 1'b1; end
          default: begin
            decIllegal = 1'b1; decRegWrite = 1'b0; decDest = '0;
            usesRs = 1'b0; usesRt = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin decSrcB = 1'b1; decRegWrite = 1'b1; decDest = rt; usesRs = 1'b1; end
      6'h23: begin
        decSrcB = 1'b1; decMemRead = 1'b1; decMemToReg = 1'b1;
        decRegWrite = 1'b1; decDest = rt; usesRs = 1'b1;
      end
      6'h2b: begin decSrcB = 1'b1; decMemWrite = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
      6'h04, 6'h05: begin decAlu = ALU_SUB; decBranch = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
      6'h0c: begin decAlu = ALU_AND; decSrcB = 1'b1; decRegWrite = 1'b1; decDest = rt; usesRs = 1'b1; end
      6'h0d: begin decAlu = ALU_OR;  decSrcB = 1'b1; decRegWrite = 1'b1; decDest = rt; usesRs = 1'b1; end
      6'h0e: begin decAlu = ALU_XOR; decSrcB = 1'b1; decRegWrite = 1'b1; decDest = rt; usesRs = 1'b1; end
      6'h0a: begin decAlu = ALU_SLT; decSrcB = 1'b1; decRegWrite = 1'b1; decDest = rt; usesRs = 1'b1; end
      6'h02: decJump = 1'b1;
      6'h03: begin decJump = 1'b1; decJal = 1'b1; decRegWrite = 1'b1; decDest = REG_AW'(31); end
      default: decIllegal = 1'b1;
    endcase
  end

  assign regWriteEff = decRegWrite && (decDest != '0);

  assign exMatch  = (usesRs && (rs != '0) && (rs == ex_dest))  || (usesRt && (rt != '0) && (rt == ex_dest));
  assign memMatch = (usesRs && (rs != '0) && (rs == mem_dest)) || (usesRt && (rt != '0) && (rt == mem_dest));
  assign loadUse  = id_valid && ex_valid && ex_mem_read && exMatch;
  assign rawHazard = (ENABLE_FWD == 0) && id_valid &&
                     ((ex_reg_write && exMatch) || (mem_reg_write && memMatch));

  // Taken branch outranks the stall counter, which outranks new hazards and jumps.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    bubble = 1'b1;
    cntNext = cnt;
    if (!CTRL_UNIT_RST) begin
      if (branch_taken_ex) begin
        flush = 1'b1;
        cntNext = '0;
      end else if (cnt != '0) begin
        stall = 1'b1;
        cntNext = cnt - 1'b1;
      end else if (loadUse) begin
        stall = 1'b1;
        cntNext = CNT_W'(STALL_CYCLES - 1);
      end else if (rawHazard) begin
        stall = 1'b1;
      end else begin
        bubble = !id_valid;
        flush = id_valid && decJump;
      end
    end
  end

  assign stall_if_id = stall;
  assign flush_if_id = flush;

  always_ff @(posedge CLK) begin
    if (CTRL_UNIT_RST || bubble) begin
      ex_valid <= 1'b0; ex_alu_op <= '0; ex_src_a <= 1'b0; ex_src_b <= 1'b0;
      ex_branch <= 1'b0; ex_mem_read <= 1'b0; ex_reg_write <= 1'b0; ex_dest <= '0;
      ex_illegal <= 1'b0; exMemWrite <= 1'b0; exMemToReg <= 1'b0; exJal <= 1'b0;
    end else begin
      ex_valid <= 1'b1; ex_alu_op <= ALUOP_W'(decAlu); ex_src_a <= decSrcA; ex_src_b <= decSrcB;
      ex_branch <= decBranch; ex_mem_read <= decMemRead; ex_reg_write <= regWriteEff;
      ex_dest <= decDest; ex_illegal <= decIllegal; exMemWrite <= decMemWrite;
      exMemToReg <= decMemToReg; exJal <= decJal;
    end
    cnt <= CTRL_UNIT_RST ? '0 : cntNext;
  end

  always_ff @(posedge CLK) begin
    if (CTRL_UNIT_RST) begin
      mem_valid <= 1'b0; mem_read <= 1'b0; mem_write <= 1'b0; mem_to_reg <= 1'b0;
      mem_reg_write <= 1'b0; mem_dest <= '0; memJal <= 1'b0;
      wb_valid <= 1'b0; wb_reg_write <= 1'b0; wb_mem_to_reg <= 1'b0; wb_jal <= 1'b0; wb_dest <= '0;
    end else begin
      mem_valid <= ex_valid; mem_read <= ex_mem_read; mem_write <= exMemWrite;
      mem_to_reg <= exMemToReg; mem_reg_write <= ex_reg_write; mem_dest <= ex_dest; memJal <= exJal;
      wb_valid <= mem_valid; wb_reg_write <= mem_reg_write; wb_mem_to_reg <= mem_to_reg;
      wb_jal <= memJal; wb_dest <= mem_dest;
    end
  end

endmodule
